// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-RAM access unit: funct3 codes, FSM states
// and the request legality check used when a request is accepted.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, RESP} mau_state_t;

    // A request is bad when the width is misaligned or the funct3 code does
    // not exist for that direction (stores have no unsigned variants).
    function automatic logic req_is_bad(input logic wr, input logic [2:0] f3,
                                        input logic [1:0] lane);
        logic bad;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = lane[0];
            F3_W:    bad = (lane != 2'b00);
            F3_BU:   bad = wr;
            F3_HU:   bad = wr | lane[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundles for the two sides of the access unit: the core request/response
// channel and the word-addressed RAM port.

// Core-facing request/response channel; the core is the master.
interface mem_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

// RAM-facing word port; the access unit is the master.
interface mem_ram_if #(parameter int ADDR_W = 10);
    logic              MemWrite;
    logic [ADDR_W-1:0] address;
    logic [31:0]       write_data;
    logic [31:0]       read_data;

    modport master (
        output MemWrite, address, write_data,
        input  read_data
    );

    modport slave (
        input  MemWrite, address, write_data,
        output read_data
    );
endinterface

// File: rtl/mem_lane_align.sv
// Byte/half lane handling: extracts and extends load data from a RAM word,
// and merges right-aligned store data into the addressed lane of a word.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Pick the addressed byte/half and extend it according to funct3.
    always_comb begin
        sel_byte = rd_word[7:0];
        case (lane)
            2'd0: sel_byte = rd_word[7:0];
            2'd1: sel_byte = rd_word[15:8];
            2'd2: sel_byte = rd_word[23:16];
            2'd3: sel_byte = rd_word[31:24];
            default: sel_byte = rd_word[7:0];
        endcase
        sel_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_data = {24'd0, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_data = {16'd0, sel_half};
            default: load_data = rd_word;
        endcase
    end

    // Replace only the addressed lane; the rest keeps the old RAM contents.
    always_comb begin
        store_word = rd_word;
        case (funct3)
            F3_B: begin
                case (lane)
                    2'd0: store_word[7:0]   = wdata[7:0];
                    2'd1: store_word[15:8]  = wdata[7:0];
                    2'd2: store_word[23:16] = wdata[7:0];
                    2'd3: store_word[31:24] = wdata[7:0];
                    default: store_word = rd_word;
                endcase
            end
            F3_H: begin
                if (lane[1]) store_word[31:16] = wdata[15:0];
                else         store_word[15:0]  = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the data-RAM port: converts core load/store requests
// into RAM word cycles, doing sub-word stores as read-modify-write.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 10
)(
    input logic       CLK,
    input logic       RST,
    mem_req_if.slave  req,
    mem_ram_if.master ram
);

    mau_state_t  state;
    logic        lat_write;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_lane;
    logic [31:0] lat_wdata;
    logic [31:0] load_data;
    logic [31:0] store_word;
    logic        unused_addr_hi;

    // Address bits above the RAM window wrap silently.
    assign unused_addr_hi = ^req.req_addr[31:ADDR_W+2];

    // Ready only while idle and not being reset.
    assign req.req_ready = (state == IDLE) && !RST;

    mem_lane_align u_align (
        .rd_word    (ram.read_data),
        .wdata      (lat_wdata),
        .lane       (lat_lane),
        .funct3     (lat_funct3),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Request FSM with registered RAM and response outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= IDLE;
            lat_write      <= 1'b0;
            lat_funct3     <= F3_B;
            lat_lane       <= 2'd0;
            lat_wdata      <= 32'd0;
            ram.MemWrite   <= 1'b0;
            ram.address    <= '0;
            ram.write_data <= 32'd0;
            req.resp_valid <= 1'b0;
            req.resp_err   <= 1'b0;
            req.resp_rdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    req.resp_valid <= 1'b0;
                    ram.MemWrite   <= 1'b0;
                    if (req.req_valid) begin
                        lat_write   <= req.req_write;
                        lat_funct3  <= req.req_funct3;
                        lat_lane    <= req.req_addr[1:0];
                        lat_wdata   <= req.req_wdata;
                        ram.address <= req.req_addr[ADDR_W+1:2];
                        if (req_is_bad(req.req_write, req.req_funct3, req.req_addr[1:0])) begin
                            req.resp_valid <= 1'b1;
                            req.resp_err   <= 1'b1;
                            req.resp_rdata <= 32'd0;
                            state          <= RESP;
                        end else if (req.req_write && req.req_funct3 == F3_W) begin
                            ram.MemWrite   <= 1'b1;
                            ram.write_data <= req.req_wdata;
                            state          <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    if (lat_write) begin
                        ram.write_data <= store_word;
                        ram.MemWrite   <= 1'b1;
                        state          <= WRITE;
                    end else begin
                        req.resp_rdata <= load_data;
                        req.resp_err   <= 1'b0;
                        req.resp_valid <= 1'b1;
                        state          <= RESP;
                    end
                end
                WRITE: begin
                    ram.MemWrite   <= 1'b0;
                    req.resp_valid <= 1'b1;
                    req.resp_err   <= 1'b0;
                    req.resp_rdata <= 32'd0;
                    state          <= RESP;
                end
                RESP: begin
                    req.resp_valid <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    ram.MemWrite <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule
